cpu_traffic_gen: RTL and testbench
==================================

CPU_TRAFFIC_GEN -- requirements
Module: cpu_traffic_gen

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 24, meaning number of word-address bits driven on cpuAddr[ADDR_W:1].
REQ-002 The block SHALL have parameter NUM_WORDS, default 256, meaning the word count per pass; legal range 1..65535.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, meaning the first word address.
REQ-004 The block SHALL have parameter STRIDE, default 1, meaning the word-address increment.
REQ-005 The block SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the data-pattern seed; must be nonzero.
REQ-006 The block SHALL have parameter NCS_HOLD, default 3, meaning idle cycles of cpu_ncs high after each completed access.
REQ-007 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_114, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle start pulse.
- mode, in, 2: 00 write then verify; 01 write only; 10 verify only; 11 reserved, treated as 00.
- longword, in, 1, request paired 32-bit accesses (see Configuration).
- cpuAddr, out, ADDR_W, word address.
- cpuState, out, 2: 01 idle, 10 read, 11 write.
- cpu_ncs, out, 1, active-low chip select.
- cpuLongWord, out, 1, longword access flag.
- cpuL, out, 1, active-low lower byte enable.
- cpuU, out, 1, active-low upper byte enable.
- cpuWR, out, 16, write data.
- cpuRD, in, 16, read data.
- enaWRreg, in, 1, controller 28 MHz enable.
- cpuena, in, 1, controller access-complete.
- clkena, out, 1, CPU step strobe.
- busy, out, 1, pass in progress.
- done, out, 1, one-cycle pulse at end of pass.
- err_count, out, 16, saturating mismatch count.
- first_err_addr, out, ADDR_W, address of first mismatch.

Function
REQ-008 clkena SHALL equal enaWRreg AND (cpuState==01 OR cpuena), combinationally.
REQ-009 The FSM SHALL have the states IDLE, WRITE, READ, and DONE.
REQ-010 In IDLE with start=1, the FSM SHALL load idx=0, load the LFSR with LFSR_SEED, and enter WRITE when mode is 00, 01, or 11, or READ when mode is 10; start outside IDLE SHALL be ignored.
REQ-011 In WRITE, the block SHALL drive cpuState=11, cpuL=cpuU=0, cpuWR=LFSR, and cpuAddr=BASE_ADDR+idx*STRIDE truncated to ADDR_W bits (wrap-around, no error).
REQ-012 In READ, the block SHALL drive cpuState=10 and cpuL=cpuU=0.
REQ-013 An access SHALL complete on a cycle with clkena=1 and cpu_ncs=0.
- On completion, the LFSR SHALL step (x^16+x^14+x^13+x^11) and idx SHALL increment.
- The NCS_HOLD counter SHALL reload.
REQ-014 cpu_ncs SHALL be high whenever cpuState==01 or the NCS_HOLD counter is nonzero; address, data and state SHALL stay stable while cpu_ncs is high.
REQ-015 On a READ completion, the block SHALL compare cpuRD with the current LFSR value.
- On mismatch, err_count SHALL increment and saturate at 16'hFFFF.
- first_err_addr SHALL be captured only on the first mismatch since start.
REQ-016 On the WRITE completion with idx==NUM_WORDS-1:
- mode 01 SHALL go to DONE.
- Other modes SHALL reload idx and the LFSR and go to READ.
REQ-017 On the READ completion with idx==NUM_WORDS-1, the FSM SHALL go to DONE.
REQ-018 DONE SHALL drive cpuState=01, pulse done for one cycle, and return to IDLE; err_count and first_err_addr SHALL hold until the next start, which clears them.
REQ-019 busy SHALL be 1 in WRITE and READ and 0 otherwise.

Reset
REQ-020 Reset, including mid-access, SHALL force the following on the next clock edge, abandoning any in-flight access with no completion counted:
- FSM to IDLE.
- cpuState=01, cpu_ncs=1, cpuL=cpuU=1, cpuLongWord=0.
- cpuAddr=0, cpuWR=0.
- busy=0, done=0.
- err_count=0, first_err_addr=0.
- LFSR=LFSR_SEED, idx=0, NCS_HOLD counter=0.

Configuration
REQ-021 With CPU_TRAFFIC_GEN_LONGWORD_EN defined and longword=1 at start:
- cpuLongWord SHALL be 1 on even idx and 0 on odd idx.
- The odd-idx access SHALL be issued with NCS_HOLD forced to 0.
- An odd NUM_WORDS SHALL end with a lone word access with cpuLongWord=0.
REQ-022 Without CPU_TRAFFIC_GEN_LONGWORD_EN, cpuLongWord SHALL be tied to 0 and longword SHALL be ignored.

Verification
REQ-023 Reset held 2 cycles during a WRITE -> next cycle cpuState=01, cpu_ncs=1, busy=0, err_count=0.
REQ-024 NUM_WORDS=4, mode 00, ideal SDRAM model -> 4 writes of data 16'hACE1 followed by 3 LFSR steps, then 4 reads; done pulses once and err_count=0.
REQ-025 mode 10 on memory of zeros, NUM_WORDS=8 -> err_count=8, first_err_addr=BASE_ADDR.
REQ-026 ADDR_W=4, BASE_ADDR=14, STRIDE=1, NUM_WORDS=4 -> addresses 14, 15, 0, 1.
REQ-027 NCS_HOLD=3 -> cpu_ncs high for exactly 3 cycles after each completion; start asserted while busy has no effect.
REQ-028 CPU_TRAFFIC_GEN_LONGWORD_EN defined, longword=1, NUM_WORDS=3 -> cpuLongWord pattern 1, 0, 0 per pass; undefined -> all 0.

Source files
------------

// File: rtl/cpu_traffic_gen.sv
// cpu_traffic_gen: drives a 68k-style CPU port of an SDRAM controller with
// an LFSR data pattern, writing a block of words and reading it back.
//
// Parameters:
//   ADDR_W     word-address bits on cpuAddr[ADDR_W:1] (up to 32)
//   NUM_WORDS  words per pass (1..65535)
//   BASE_ADDR  first word address
//   STRIDE     word-address increment per access
//   LFSR_SEED  data-pattern seed (nonzero)
//   NCS_HOLD   cycles cpu_ncs stays high after each completed access
//
// Ports:
//   clk_114          sole clock
//   reset            synchronous active-high reset
//   start            one-cycle start pulse, honoured only when idle
//   mode             00 write+verify, 01 write, 10 verify, 11 as 00
//   longword         request paired 32-bit accesses (optional feature)
//   cpuAddr          word address
//   cpuState         01 idle, 10 read, 11 write
//   cpu_ncs          active-low chip select
//   cpuLongWord      longword access flag
//   cpuL, cpuU       active-low byte enables
//   cpuWR / cpuRD    write / read data
//   enaWRreg         controller 28 MHz enable
//   cpuena           controller access-complete
//   clkena           CPU step strobe
//   busy             pass in progress
//   done             one-cycle pulse at end of pass
//   err_count        saturating mismatch count
//   first_err_addr   address of the first mismatch since start
//
// Optional feature: define CPU_TRAFFIC_GEN_LONGWORD_EN to honour the
// longword input. Without it cpuLongWord is tied low and longword ignored.

module cpu_traffic_gen #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned STRIDE    = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned NCS_HOLD  = 3
) (
    input  logic              clk_114,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              longword,
    output logic [ADDR_W:1]   cpuAddr,
    output logic [1:0]        cpuState,
    output logic              cpu_ncs,
    output logic              cpuLongWord,
    output logic              cpuL,
    output logic              cpuU,
    output logic [15:0]       cpuWR,
    input  logic [15:0]       cpuRD,
    input  logic              enaWRreg,
    input  logic              cpuena,
    output logic              clkena,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] CS_IDLE  = 2'b01;
    localparam logic [1:0] CS_READ  = 2'b10;
    localparam logic [1:0] CS_WRITE = 2'b11;

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [15:0]       LAST_IDX = 16'(NUM_WORDS - 1);
    localparam logic [15:0]       HOLD_RLD = 16'(NCS_HOLD);

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       idx_q, idx_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       hold_q, hold_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;

    logic in_access;
    logic last_word;
    logic complete;
    logic pair_lo;
    logic write_only;

    // Fibonacci form of x^16+x^14+x^13+x^11, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

`ifdef CPU_TRAFFIC_GEN_LONGWORD_EN
    logic lw_q, lw_d;

    always_comb begin
        lw_d = lw_q;
        if (state_q == S_IDLE && start) begin
            lw_d = longword;
        end
    end

    always_ff @(posedge clk_114) begin
        if (reset) begin
            lw_q <= 1'b0;
        end else begin
            lw_q <= lw_d;
        end
    end

    // Even index opens a pair unless it is the last word of an odd pass,
    // which goes out as a lone word access.
    assign pair_lo = lw_q & ~idx_q[0] & (idx_q != LAST_IDX);
`else
    logic unused_longword;

    assign unused_longword = longword;
    assign pair_lo         = 1'b0;
`endif

    assign in_access  = (state_q == S_WRITE) || (state_q == S_READ);
    assign last_word  = (idx_q == LAST_IDX);
    assign write_only = (mode_q == 2'b01);

    always_comb begin
        cpuState = CS_IDLE;
        cpuL     = 1'b1;
        cpuU     = 1'b1;
        cpuWR    = '0;
        busy     = 1'b0;
        unique case (state_q)
            S_WRITE: begin
                cpuState = CS_WRITE;
                cpuL     = 1'b0;
                cpuU     = 1'b0;
                cpuWR    = lfsr_q;
                busy     = 1'b1;
            end
            S_READ: begin
                cpuState = CS_READ;
                cpuL     = 1'b0;
                cpuU     = 1'b0;
                busy     = 1'b1;
            end
            default: begin
                cpuState = CS_IDLE;
            end
        endcase
    end

    assign cpuAddr        = addr_q;
    assign cpuLongWord    = in_access & pair_lo;
    assign cpu_ncs        = (cpuState == CS_IDLE) || (hold_q != '0);
    assign clkena         = enaWRreg & ((cpuState == CS_IDLE) | cpuena);
    assign complete       = clkena & ~cpu_ncs;
    assign done           = (state_q == S_DONE);
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        addr_d  = addr_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        hold_d  = (hold_q != '0) ? hold_q - 16'd1 : hold_q;

        // The second half of a longword pair follows with no gap.
        if (complete) begin
            hold_d = pair_lo ? 16'd0 : HOLD_RLD;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (mode == 2'b10) ? S_READ : S_WRITE;
                    mode_d  = mode;
                    idx_d   = '0;
                    lfsr_d  = LFSR_SEED;
                    addr_d  = BASE_A;
                    err_d   = '0;
                    ferr_d  = '0;
                    hold_d  = '0;
                end
            end
            S_WRITE: begin
                if (complete) begin
                    if (!last_word) begin
                        idx_d  = idx_q + 16'd1;
                        lfsr_d = lfsr_step(lfsr_q);
                        addr_d = addr_q + STRIDE_A;
                    end else if (write_only) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        idx_d   = '0;
                        lfsr_d  = LFSR_SEED;
                        addr_d  = BASE_A;
                    end
                end
            end
            S_READ: begin
                if (complete) begin
                    if (cpuRD != lfsr_q) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                        // A saturating count never returns to zero, so
                        // zero means no mismatch yet in this pass.
                        if (err_q == '0) begin
                            ferr_d = addr_q;
                        end
                    end
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        lfsr_d = lfsr_step(lfsr_q);
                        addr_d = addr_q + STRIDE_A;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_114) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            idx_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            addr_q  <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// tb_cpu_traffic_gen: directed checks of cpu_traffic_gen on three
// parameter sets sharing one control bus, each with its own memory model.

module tb_cpu_traffic_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, longword, enaWRreg, cpuena;
    logic [1:0] mode;

    logic [1:0]  st_a, st_b, st_c;
    logic [3:0]  addr_a;
    logic [23:0] addr_b, addr_c;
    logic        ncs_a, ncs_b, ncs_c;
    logic        lw_a, lw_b, lw_c;
    logic        l_a, l_b, l_c, u_a, u_b, u_c;
    logic [15:0] wr_a, wr_b, wr_c, rd_a, rd_b, rd_c;
    logic        clke_a, clke_b, clke_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [15:0] err_a, err_b, err_c;
    logic [3:0]  ferr_a;
    logic [23:0] ferr_b, ferr_c;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [256];
    logic [15:0] mem_c [256];
    logic [15:0] flip_b [256];
    logic        zero_b;

    assign rd_a = mem_a[addr_a];
    assign rd_b = zero_b ? 16'h0000 : (mem_b[addr_b[7:0]] ^ flip_b[addr_b[7:0]]);
    assign rd_c = mem_c[addr_c[7:0]];

    cpu_traffic_gen #(.ADDR_W(4), .NUM_WORDS(4), .BASE_ADDR(14), .STRIDE(1)) dut_a (
        .clk_114(clk), .reset(reset), .start(start), .mode(mode), .longword(longword),
        .cpuAddr(addr_a), .cpuState(st_a), .cpu_ncs(ncs_a), .cpuLongWord(lw_a),
        .cpuL(l_a), .cpuU(u_a), .cpuWR(wr_a), .cpuRD(rd_a), .enaWRreg(enaWRreg),
        .cpuena(cpuena), .clkena(clke_a), .busy(busy_a), .done(done_a),
        .err_count(err_a), .first_err_addr(ferr_a));

    cpu_traffic_gen #(.NUM_WORDS(8), .BASE_ADDR(24'h100), .STRIDE(3)) dut_b (
        .clk_114(clk), .reset(reset), .start(start), .mode(mode), .longword(longword),
        .cpuAddr(addr_b), .cpuState(st_b), .cpu_ncs(ncs_b), .cpuLongWord(lw_b),
        .cpuL(l_b), .cpuU(u_b), .cpuWR(wr_b), .cpuRD(rd_b), .enaWRreg(enaWRreg),
        .cpuena(cpuena), .clkena(clke_b), .busy(busy_b), .done(done_b),
        .err_count(err_b), .first_err_addr(ferr_b));

    cpu_traffic_gen #(.NUM_WORDS(3)) dut_c (
        .clk_114(clk), .reset(reset), .start(start), .mode(mode), .longword(longword),
        .cpuAddr(addr_c), .cpuState(st_c), .cpu_ncs(ncs_c), .cpuLongWord(lw_c),
        .cpuL(l_c), .cpuU(u_c), .cpuWR(wr_c), .cpuRD(rd_c), .enaWRreg(enaWRreg),
        .cpuena(cpuena), .clkena(clke_c), .busy(busy_c), .done(done_c),
        .err_count(err_c), .first_err_addr(ferr_c));

    typedef struct packed {
        logic [1:0]  st;
        logic [23:0] addr;
        logic [15:0] wd;
        logic        lw;
        logic [31:0] cyc;
    } rec_t;

    rec_t q_a[$];
    rec_t q_b[$];
    rec_t q_c[$];
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Completed accesses: logged and, for writes, stored in memory.
    always @(posedge clk) begin
        if (!reset) begin
            if (!ncs_a && clke_a) begin
                q_a.push_back('{st: st_a, addr: 24'(addr_a), wd: wr_a, lw: lw_a, cyc: cyc});
                if (st_a == 2'b11) mem_a[addr_a] <= wr_a;
            end
            if (!ncs_b && clke_b) begin
                q_b.push_back('{st: st_b, addr: addr_b, wd: wr_b, lw: lw_b, cyc: cyc});
                if (st_b == 2'b11) mem_b[addr_b[7:0]] <= wr_b;
            end
            if (!ncs_c && clke_c) begin
                q_c.push_back('{st: st_c, addr: addr_c, wd: wr_c, lw: lw_c, cyc: cyc});
                if (st_c == 2'b11) mem_c[addr_c[7:0]] <= wr_c;
            end
        end
    end

    int total  = 0;
    int passed = 0;
    int dn_a, dn_b, dn_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_all(input bit do_start);
        bit fin;
        fin  = 1'b0;
        dn_a = 0;
        dn_b = 0;
        dn_c = 0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < 600 && !fin; i++) begin
            tick();
            dn_a += int'(done_a);
            dn_b += int'(done_b);
            dn_c += int'(done_c);
            if (!busy_a && !busy_b && !busy_c && !done_a && !done_b && !done_c)
                fin = 1'b1;
        end
        total++;
        if (!fin) $display("FAIL run_timeout got busy %b%b%b want 000", busy_a, busy_b, busy_c);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (st_a !== 2'b01) $display("FAIL rst_state got %b want 01", st_a); else passed++;
        total++; if (ncs_a !== 1'b1) $display("FAIL rst_ncs got %b want 1", ncs_a); else passed++;
        total++; if ({l_a, u_a} !== 2'b11) $display("FAIL rst_lu got %b want 11", {l_a, u_a}); else passed++;
        total++; if (lw_a !== 1'b0) $display("FAIL rst_lw got %b want 0", lw_a); else passed++;
        total++; if (addr_a !== 4'd0) $display("FAIL rst_addr got %h want 0", addr_a); else passed++;
        total++; if (wr_a !== 16'd0) $display("FAIL rst_wr got %h want 0", wr_a); else passed++;
        total++; if ({busy_a, done_a} !== 2'b00) $display("FAIL rst_busy_done got %b want 00", {busy_a, done_a}); else passed++;
        total++; if (err_a !== 16'd0) $display("FAIL rst_err got %h want 0", err_a); else passed++;
        total++; if (ferr_b !== 24'd0) $display("FAIL rst_ferr got %h want 0", ferr_b); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clkena();
        int base;
        base     = q_a.size();
        enaWRreg = 1'b1;
        cpuena   = 1'b0;
        #1;
        total++; if (clke_a !== 1'b1) $display("FAIL clkena_idle got %b want 1", clke_a); else passed++;
        enaWRreg = 1'b0;
        #1;
        total++; if (clke_a !== 1'b0) $display("FAIL clkena_idle_noena got %b want 0", clke_a); else passed++;
        enaWRreg = 1'b1;
        mode     = 2'b01;
        start    = 1'b1;
        tick();
        start = 1'b0;
        total++; if (st_a !== 2'b11) $display("FAIL wr_state got %b want 11", st_a); else passed++;
        total++; if ({l_a, u_a} !== 2'b00) $display("FAIL wr_lu got %b want 00", {l_a, u_a}); else passed++;
        total++; if (wr_a !== 16'hACE1) $display("FAIL wr_first_data got %h want ace1", wr_a); else passed++;
        total++; if (clke_a !== 1'b0) $display("FAIL clkena_wait got %b want 0", clke_a); else passed++;
        tick();
        tick();
        tick();
        total++; if (addr_a !== 4'd14) $display("FAIL stall_addr got %0d want 14", addr_a); else passed++;
        total++; if (ncs_a !== 1'b0) $display("FAIL stall_ncs got %b want 0", ncs_a); else passed++;
        enaWRreg = 1'b0;
        cpuena   = 1'b1;
        #1;
        total++; if (clke_a !== 1'b0) $display("FAIL clkena_noena got %b want 0", clke_a); else passed++;
        enaWRreg = 1'b1;
        #1;
        total++; if (clke_a !== 1'b1) $display("FAIL clkena_cpuena got %b want 1", clke_a); else passed++;
        run_all(1'b0);
        total++; if (q_a.size() - base !== 4) $display("FAIL wronly_count got %0d want 4", q_a.size() - base); else passed++;
        total++; if (dn_a !== 1) $display("FAIL wronly_done got %0d want 1", dn_a); else passed++;
    endtask

    task automatic test_write_verify();
        logic [15:0] exp_d [4];
        logic [3:0]  exp_ad [4];
        rec_t        r;
        int          base;
        exp_d  = '{16'hACE1, 16'h5670, 16'hAB38, 16'h559C};
        exp_ad = '{4'd14, 4'd15, 4'd0, 4'd1};
        base   = q_a.size();
        mode   = 2'b00;
        run_all(1'b1);
        total++; if (q_a.size() - base !== 8) $display("FAIL wv_count got %0d want 8", q_a.size() - base); else passed++;
        for (int i = 0; i < 8; i++) begin
            r = (base + i < q_a.size()) ? q_a[base + i] : '0;
            total++;
            if (r.st !== ((i < 4) ? 2'b11 : 2'b10)) $display("FAIL wv_state[%0d] got %b", i, r.st);
            else passed++;
            total++;
            if (r.addr !== 24'(exp_ad[i % 4])) $display("FAIL wv_addr[%0d] got %0d want %0d", i, r.addr, exp_ad[i % 4]);
            else passed++;
            if (i < 4) begin
                total++;
                if (r.wd !== exp_d[i]) $display("FAIL wv_data[%0d] got %h want %h", i, r.wd, exp_d[i]);
                else passed++;
            end
        end
        total++; if (dn_a !== 1) $display("FAIL wv_done got %0d want 1", dn_a); else passed++;
        total++; if (err_a !== 16'd0) $display("FAIL wv_err_a got %0d want 0", err_a); else passed++;
        total++; if (err_b !== 16'd0) $display("FAIL wv_err_b got %0d want 0", err_b); else passed++;
        total++; if (err_c !== 16'd0) $display("FAIL wv_err_c got %0d want 0", err_c); else passed++;
    endtask

    task automatic test_first_err();
        flip_b[8'h06] = 16'h0001;
        flip_b[8'h0F] = 16'h8000;
        mode = 2'b10;
        run_all(1'b1);
        total++; if (err_b !== 16'd2) $display("FAIL ferr_count got %0d want 2", err_b); else passed++;
        total++; if (ferr_b !== 24'h106) $display("FAIL ferr_addr got %h want 106", ferr_b); else passed++;
        total++; if (err_a !== 16'd0) $display("FAIL ferr_clean got %0d want 0", err_a); else passed++;
        total++; if (dn_b !== 1) $display("FAIL ferr_done got %0d want 1", dn_b); else passed++;
        flip_b[8'h06] = 16'h0000;
        flip_b[8'h0F] = 16'h0000;
    endtask

    task automatic test_verify_zeros();
        zero_b = 1'b1;
        mode   = 2'b10;
        run_all(1'b1);
        total++; if (err_b !== 16'd8) $display("FAIL zeros_count got %0d want 8", err_b); else passed++;
        total++; if (ferr_b !== 24'h100) $display("FAIL zeros_addr got %h want 100", ferr_b); else passed++;
        zero_b = 1'b0;
    endtask

    task automatic test_ncs_hold();
        int   base_a, base_c, n;
        rec_t r0, r1, r2;
        base_a   = q_a.size();
        base_c   = q_c.size();
        longword = 1'b0;
        mode     = 2'b01;
        start    = 1'b1;
        tick();
        start = 1'b0;
        total++; if (ncs_c !== 1'b0) $display("FAIL hold_first_ncs got %b want 0", ncs_c); else passed++;
        tick();
        n = 0;
        while (ncs_c === 1'b1 && n < 10) begin
            start = (n == 1);
            mode  = 2'b10;
            tick();
            n++;
        end
        start = 1'b0;
        total++; if (n !== 3) $display("FAIL hold_cycles got %0d want 3", n); else passed++;
        run_all(1'b0);
        total++; if (q_c.size() - base_c !== 3) $display("FAIL busy_start_c got %0d want 3", q_c.size() - base_c); else passed++;
        total++; if (q_a.size() - base_a !== 4) $display("FAIL busy_start_a got %0d want 4", q_a.size() - base_a); else passed++;
        r0 = (base_c + 0 < q_c.size()) ? q_c[base_c + 0] : '0;
        r1 = (base_c + 1 < q_c.size()) ? q_c[base_c + 1] : '0;
        r2 = (base_c + 2 < q_c.size()) ? q_c[base_c + 2] : '0;
        total++; if ({r0.st, r1.st, r2.st} !== 6'b111111) $display("FAIL busy_start_st got %b want 111111", {r0.st, r1.st, r2.st}); else passed++;
        total++; if (r2.addr !== 24'd2) $display("FAIL busy_start_addr got %0d want 2", r2.addr); else passed++;
        total++; if (r1.cyc - r0.cyc !== 32'd4) $display("FAIL hold_gap got %0d want 4", r1.cyc - r0.cyc); else passed++;
        total++; if (dn_c !== 1) $display("FAIL hold_done got %0d want 1", dn_c); else passed++;
    endtask

    task automatic test_longword();
        logic [5:0] lwc;
        logic [7:0] lwa;
        logic [31:0] gap;
        rec_t r, s;
        int base_a, base_c;
`ifdef CPU_TRAFFIC_GEN_LONGWORD_EN
        lwc = 6'b001001;
        lwa = 8'b01010101;
        gap = 32'd1;
`else
        lwc = 6'b000000;
        lwa = 8'b00000000;
        gap = 32'd4;
`endif
        base_a   = q_a.size();
        base_c   = q_c.size();
        longword = 1'b1;
        mode     = 2'b00;
        run_all(1'b1);
        longword = 1'b0;
        total++; if (q_c.size() - base_c !== 6) $display("FAIL lw_count got %0d want 6", q_c.size() - base_c); else passed++;
        for (int i = 0; i < 6; i++) begin
            r = (base_c + i < q_c.size()) ? q_c[base_c + i] : '0;
            total++;
            if (r.lw !== lwc[i]) $display("FAIL lw_c[%0d] got %b want %b", i, r.lw, lwc[i]);
            else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            r = (base_a + i < q_a.size()) ? q_a[base_a + i] : '0;
            total++;
            if (r.lw !== lwa[i]) $display("FAIL lw_a[%0d] got %b want %b", i, r.lw, lwa[i]);
            else passed++;
        end
        r = (base_c < q_c.size()) ? q_c[base_c] : '0;
        s = (base_c + 1 < q_c.size()) ? q_c[base_c + 1] : '0;
        total++; if (s.cyc - r.cyc !== gap) $display("FAIL lw_pair_gap got %0d want %0d", s.cyc - r.cyc, gap); else passed++;
        r = (base_a + 1 < q_a.size()) ? q_a[base_a + 1] : '0;
        s = (base_a + 2 < q_a.size()) ? q_a[base_a + 2] : '0;
        total++; if (s.cyc - r.cyc !== 32'd4) $display("FAIL lw_after_pair_gap got %0d want 4", s.cyc - r.cyc); else passed++;
        total++; if (err_c !== 16'd0) $display("FAIL lw_err got %0d want 0", err_c); else passed++;
    endtask

    task automatic test_reset_mid();
        mode  = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if (st_a !== 2'b11) $display("FAIL mid_pre_state got %b want 11", st_a); else passed++;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (st_a !== 2'b01) $display("FAIL mid_state got %b want 01", st_a); else passed++;
        total++; if (ncs_a !== 1'b1) $display("FAIL mid_ncs got %b want 1", ncs_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL mid_busy got %b want 0", busy_a); else passed++;
        total++; if (addr_a !== 4'd0) $display("FAIL mid_addr got %0d want 0", addr_a); else passed++;
        tick();
        total++; if ({busy_a, done_a} !== 2'b00) $display("FAIL mid_after got %b want 00", {busy_a, done_a}); else passed++;
        zero_b = 1'b1;
        mode   = 2'b10;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++; if (err_b === 16'd0) $display("FAIL mid_pre_err got %0d want nonzero", err_b); else passed++;
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        zero_b = 1'b0;
        total++; if (err_b !== 16'd0) $display("FAIL mid_err got %0d want 0", err_b); else passed++;
        total++; if (ferr_b !== 24'd0) $display("FAIL mid_ferr got %h want 0", ferr_b); else passed++;
        total++; if ({st_b, ncs_b, lw_b} !== 4'b0110) $display("FAIL mid_b_port got %b want 0110", {st_b, ncs_b, lw_b}); else passed++;
        tick();
        total++; if ({busy_b, done_b} !== 2'b00) $display("FAIL mid_b_after got %b want 00", {busy_b, done_b}); else passed++;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'b00;
        longword = 1'b0;
        enaWRreg = 1'b1;
        cpuena   = 1'b1;
        zero_b   = 1'b0;
        for (int i = 0; i < 256; i++) flip_b[i] = 16'h0000;
        test_reset();
        test_clkena();
        test_write_verify();
        test_first_err();
        test_verify_zeros();
        test_ncs_hold();
        test_longword();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
